// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Contents:
//   op_e     - operation encodings seen on the op input
//   state_e  - control FSM states
//   MUL_CYCLES_DEF / DIV_CYCLES - default multiply latency, divide iterations
//   mul_64() - 32x32 -> 64 product, signed or unsigned
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES     = 32;

  // Extending both operands to 64 bits first makes a single 64-bit
  // truncated multiply correct for both signed and unsigned products.
  function automatic logic [63:0] mul_64(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        is_signed);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    if (is_signed) begin
      a_ext = {{32{a[31]}}, a};
      b_ext = {{32{b[31]}}, b};
    end else begin
      a_ext = {32'd0, a};
      b_ext = {32'd0, b};
    end
    mul_64 = a_ext * b_ext;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - load dividend/divisor and begin (one-cycle pulse)
//   dividend, divisor   - unsigned operands, sampled when start=1
//   quotient, remainder - result, valid once all iterations are complete
//   valid               - high from the last iteration until the next start
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dsr_r;
  logic [5:0]  cnt_r;
  logic        valid_r;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Trial subtraction: partial remainder shifted left with the next dividend bit.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    diff_s    = shifted_s - {1'b0, dsr_r};
  end

  // Iteration registers; the dividend shifts out of quo_r as quotient bits shift in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dsr_r   <= 32'd0;
      cnt_r   <= 6'd0;
      valid_r <= 1'b0;
    end else if (start) begin
      quo_r   <= dividend;
      rem_r   <= 32'd0;
      dsr_r   <= divisor;
      cnt_r   <= 6'(DIV_CYCLES);
      valid_r <= 1'b0;
    end else if (cnt_r != 6'd0) begin
      // diff_s[32] set means the trial went negative: restore (keep shifted value).
      if (diff_s[32] == 1'b0) begin
        rem_r <= diff_s[31:0];
        quo_r <= {quo_r[30:0], 1'b1};
      end else begin
        rem_r <= shifted_s[31:0];
        quo_r <= {quo_r[30:0], 1'b0};
      end
      cnt_r   <= cnt_r - 6'd1;
      valid_r <= (cnt_r == 6'd1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign valid     = valid_r;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start, op  - request qualifier and operation (sampled only when idle)
//   opA, opB   - rs / rt operand values after forwarding
//   flush      - abort any in-flight operation
//   busy       - multi-cycle operation in flight (registered)
//   done       - one-cycle pulse when HI/LO show a new mul/div result
//   hi, lo     - HI and LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_r;
  state_e      state_s;
  logic [4:0]  cnt_r;
  logic        ld_mul_s;
  logic        ld_div_s;
  logic        wr_hi_s;
  logic        wr_lo_s;
  logic        fin_mul_s;
  logic        fin_div_s;
  logic        op_signed_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        signed_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        div_valid_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [63:0] prod_s;

  // Operand magnitudes for the divider; signs are kept in a_r/b_r for the fixup.
  always_comb begin
    op_signed_s = (op == OP_MULT) || (op == OP_DIV);
    if ((op == OP_DIV) && opA[31]) begin
      mag_a_s = 32'd0 - opA;
    end else begin
      mag_a_s = opA;
    end
    if ((op == OP_DIV) && opB[31]) begin
      mag_b_s = 32'd0 - opB;
    end else begin
      mag_b_s = opB;
    end
  end

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (ld_div_s),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (quo_s),
    .remainder (rem_s),
    .valid     (div_valid_s)
  );

  // Sign correction and divide-by-zero override applied at writeback.
  always_comb begin
    if (b_r == 32'd0) begin
      quo_fix_s = 32'hFFFF_FFFF;
      rem_fix_s = a_r;
    end else begin
      if (signed_r && (a_r[31] ^ b_r[31])) begin
        quo_fix_s = 32'd0 - quo_s;
      end else begin
        quo_fix_s = quo_s;
      end
      if (signed_r && a_r[31]) begin
        rem_fix_s = 32'd0 - rem_s;
      end else begin
        rem_fix_s = rem_s;
      end
    end
  end

  // Product of the latched operands, consumed on the final MUL cycle.
  always_comb begin
    prod_s = mul_64(a_r, b_r, signed_r);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    state_s   = state_r;
    ld_mul_s  = 1'b0;
    ld_div_s  = 1'b0;
    wr_hi_s   = 1'b0;
    wr_lo_s   = 1'b0;
    fin_mul_s = 1'b0;
    fin_div_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op_e'(op))
            OP_MULT, OP_MULTU: begin
              state_s  = ST_MUL;
              ld_mul_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_s  = ST_DIV;
              ld_div_s = 1'b1;
            end
            OP_MTHI: wr_hi_s = 1'b1;
            OP_MTLO: wr_lo_s = 1'b1;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == 5'd0) begin
          state_s   = ST_IDLE;
          fin_mul_s = 1'b1;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == 5'd0) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_FIX: begin
        // The core finishes its last iteration on the edge that enters FIX.
        if (flush) begin
          state_s = ST_IDLE;
        end else if (div_valid_s) begin
          state_s   = ST_IDLE;
          fin_div_s = 1'b1;
        end else begin
          state_s = ST_FIX;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Cycle counter: MUL counts MUL_CYCLES-1..0, DIV counts 31..0 before FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 5'd0;
    end else if (ld_mul_s) begin
      cnt_r <= 5'(MUL_CYCLES - 1);
    end else if (ld_div_s) begin
      cnt_r <= 5'(DIV_CYCLES - 1);
    end else if (((state_r == ST_MUL) || (state_r == ST_DIV)) && (cnt_r != 5'd0)) begin
      cnt_r <= cnt_r - 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latched operands and signedness of the in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      signed_r <= 1'b0;
    end else if (ld_mul_s || ld_div_s) begin
      a_r      <= opA;
      b_r      <= opB;
      signed_r <= op_signed_s;
    end else begin
      a_r      <= a_r;
    end
  end

  // HI/LO writes plus registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= fin_mul_s | fin_div_s;
      if (fin_mul_s) begin
        hi_r <= prod_s[63:32];
        lo_r <= prod_s[31:0];
      end else if (fin_div_s) begin
        hi_r <= rem_fix_s;
        lo_r <= quo_fix_s;
      end else if (wr_hi_s) begin
        hi_r <= opA;
      end else if (wr_lo_s) begin
        lo_r <= opA;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  localparam logic [2:0] T_NOP = 3'd0, T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3,
                         T_DIVU = 3'd4, T_MTHI = 3'd5, T_MTLO = 3'd6, T_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} after the op, from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ch,
                                         input logic [31:0] cl);
    longint p;
    int sa, sb, q, r;
    case (o)
      T_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      T_MULTU: return {32'd0, a} * {32'd0, b};
      T_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
        return {32'(r), 32'(q)};
      end
      T_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      T_MTHI: return {a, cl};
      T_MTLO: return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  // Issue one op at the current negedge and follow it to completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int flush_at);
    logic [63:0] e;
    int lat, cyc;
    bit dbad, is_md;
    is_md = (o == T_MULT) || (o == T_MULTU) || (o == T_DIV) || (o == T_DIVU);
    e = ref_op(o, a, b, m_hi, m_lo);
    lat = (o == T_MULT || o == T_MULTU) ? 4 : 33;
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); opA = $urandom; opB = $urandom;
    if (!is_md) begin
      chk("single_busy", {63'd0, busy}, 64'd0);
      chk("single_done", {63'd0, done}, 64'd0);
      chk("single_hilo", {hi, lo}, e);
      m_hi = e[63:32]; m_lo = e[31:0];
      return;
    end
    cyc = 0; dbad = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done !== 1'b0) dbad = 1'b1;
      if (cyc == flush_at) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
        return;
      end
      if (cyc == poke_at) begin
        start = 1'b1; op = T_MULT; opA = $urandom; opB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'(lat));
    chk("done_low_while_busy", {63'd0, dbad}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("result_hilo", {hi, lo}, e);
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] edge_vals [6];
    edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'd1;
    edge_vals[3] = 32'h7FFF_FFFF; edge_vals[4] = 32'd0;          edge_vals[5] = 32'd7;

    #12;
    chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(T_MULT,  32'hFFFF_FFFE, 32'd3, -1, -1);
    chk("mult_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    run_op(T_MULTU, 32'hFFFF_FFFE, 32'd3, -1, -1);
    chk("multu_hi", {32'd0, hi}, 64'h2);
    run_op(T_DIV,   32'hFFFF_FFF9, 32'd2, -1, -1);
    chk("div_neg_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
    run_op(T_DIVU,  32'd100, 32'd7, -1, -1);
    chk("divu_lo", {32'd0, lo}, 64'd14);
    run_op(T_DIVU,  32'd100, 32'd0, -1, -1);
    chk("divu_zero_hi", {32'd0, hi}, 64'd100);
    run_op(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(T_DIV,   32'hFFFF_FFF0, 32'd0, -1, -1);
    run_op(T_MTHI,  32'h1234_5678, 32'd0, -1, -1);
    run_op(T_MTLO,  32'h9ABC_DEF0, 32'd0, -1, -1);
    run_op(T_NOP,   32'h5555_5555, 32'd0, -1, -1);
    run_op(T_RSVD,  32'h6666_6666, 32'd0, -1, -1);
    // MULT request while DIV is busy must be ignored.
    run_op(T_DIV,   32'd1000, 32'hFFFF_FFFD, 5, -1);
    // Flush mid-DIV and mid-MUL.
    run_op(T_DIV,   32'd12345, 32'd67, -1, 10);
    run_op(T_MULTU, 32'hDEAD_BEEF, 32'd99, -1, 2);

    // Flush coincident with start drops the request, including MTHI.
    start = 1'b1; flush = 1'b1; op = T_DIV; opA = 32'd9; opB = 32'd3;
    @(negedge clk);
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    op = T_MTHI; opA = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_mthi_hilo", {hi, lo}, {m_hi, m_lo});

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = edge_vals[$urandom_range(0, 5)];
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, -1, -1);
    end

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = T_MULT; opA = 32'h0001_0000; opB = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_now", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (4) @(negedge clk);
    chk("after_rst_quiet", {30'd0, busy, done, hi, lo}, 64'd0);
    run_op(T_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
